// File: rtl/sprite_line_engine.sv
// Per-scanline sprite renderer: scans a 32-entry attribute table on each line start and
// streams every covering sprite's row out of the shared sprite ROM into the ping-pong line buffer.
module sprite_line_engine #(
  parameter int N_SPR    = 32,
  parameter int SPR_W    = 32,
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        attr_we,
  input  logic [4:0]  attr_addr,
  input  logic [25:0] attr_wdata,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  output logic [5:0]  n_sprite,
  output logic [9:0]  spr_line,
  output logic [5:0]  spr_pixel,
  input  logic [3:0]  color_code,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [3:0]  lb_data,
  output logic        lb_sel,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int              IW       = $clog2(N_SPR);
  localparam logic [IW-1:0]   LAST_IDX = IW'(N_SPR - 1);
  localparam logic [5:0]      LAST_PIX = 6'(SPR_W - 1);
  localparam logic [10:0]     SPR_H    = 11'(SPR_W);
  localparam logic [10:0]     H_LIM    = 11'(H_ACTIVE);

  typedef enum logic [2:0] {IDLE, SCAN, DRAW, DRAIN, DONE} state_t;

  logic [25:0]   table_q [N_SPR];
  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [9:0]    line_q, x_q, spr_line_q, lb_addr_q;
  logic [5:0]    n_sprite_q, spr_pixel_q;
  logic          valid_q, lb_sel_q, busy_q, done_q, overrun_q;

  logic [25:0]   entry_d;
  logic [10:0]   line_ext_d, y_ext_d, pix_addr_d;
  logic [9:0]    row_d;
  logic          hit_d;

  // Vertical hit test is done at 11 bits so y near the bottom never wraps onto the top lines.
  assign entry_d    = table_q[idx_q];
  assign line_ext_d = {1'b0, line_q};
  assign y_ext_d    = {1'b0, entry_d[19:10]};
  assign row_d      = line_q - entry_d[19:10];
  assign hit_d      = (entry_d[25:20] != 6'd0) && (line_ext_d >= y_ext_d) &&
                      (line_ext_d < y_ext_d + SPR_H);
  assign pix_addr_d = {1'b0, x_q} + {5'd0, spr_pixel_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SPR; i++) table_q[i] <= '0;
    end else if (attr_we) begin
      table_q[attr_addr] <= attr_wdata;
    end
  end

  // A restart while busy kills the in-flight pixel so the old line never leaks into the new buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      line_q      <= '0;
      x_q         <= '0;
      spr_line_q  <= '0;
      lb_addr_q   <= '0;
      n_sprite_q  <= '0;
      spr_pixel_q <= '0;
      valid_q     <= 1'b0;
      lb_sel_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= (state_q == DRAW) && (pix_addr_d < H_LIM);
      if (state_q == DRAW) lb_addr_q <= pix_addr_d[9:0];
      if (line_start) begin
        line_q    <= next_line;
        lb_sel_q  <= next_line[0];
        idx_q     <= '0;
        state_q   <= SCAN;
        busy_q    <= 1'b1;
        valid_q   <= 1'b0;
        overrun_q <= busy_q && (state_q != DONE);
      end else begin
        case (state_q)
          IDLE: ;
          SCAN: begin
            if (hit_d) begin
              n_sprite_q  <= entry_d[25:20];
              spr_line_q  <= row_d;
              x_q         <= entry_d[9:0];
              spr_pixel_q <= 6'd0;
              state_q     <= DRAW;
            end else if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
          DRAW: begin
            if (spr_pixel_q == LAST_PIX) state_q <= DRAIN;
            else spr_pixel_q <= spr_pixel_q + 6'd1;
          end
          DRAIN: begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= SCAN;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign n_sprite  = n_sprite_q;
  assign spr_line  = spr_line_q;
  assign spr_pixel = spr_pixel_q;
  assign lb_we     = valid_q && (color_code != 4'd0) && !(line_start && busy_q);
  assign lb_addr   = lb_addr_q;
  assign lb_data   = valid_q ? color_code : 4'd0;
  assign lb_sel    = lb_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Per-scanline sprite renderer that sequences the shared `sprites` ROM bank. It holds a 32-entry sprite attribute table written by the bus side. On each `line_start` it scans the table, and for every sprite covering the requested line it streams that sprite's 32 pixels out of the ROM. Opaque color codes go into the ping-pong line buffer that feeds `sprite_color_pallete` (`select` = buffer parity).

## Interface
Parameters:
- `N_SPR`, default 32: attribute table entries; index width is 5.
- `SPR_W`, default 32: sprite width and height in pixels.
- `H_ACTIVE`, default 640: visible pixels per line; write addresses ≥ `H_ACTIVE` are clipped.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `attr_we`  in  1: attribute table write strobe.
- `attr_addr`  in  5: table index.
- `attr_wdata`  in  26: `{id[25:20], y[19:10], x[9:0]}`. `id` = 0 marks the slot empty.
- `line_start`  in  1: one-cycle pulse that starts rendering of `next_line`.
- `next_line`  in  10: screen line to render; sampled only when `line_start` = 1.
- `n_sprite`  out  6: sprite id driven to the `sprites` ROM.
- `spr_line`  out  10: row within the sprite, `next_line - y`; bits [9:5] are always 0.
- `spr_pixel`  out  6: column within the sprite, 0..31.
- `color_code`  in  4: `sprites` ROM output; valid 1 cycle after the address is presented.
- `lb_we`  out  1: line buffer write enable.
- `lb_addr`  out  10: line buffer pixel address.
- `lb_data`  out  4: color code to write.
- `lb_sel`  out  1: target buffer, equal to the latched `next_line[0]`.
- `busy`  out  1: high from the cycle after `line_start` until `done`.
- `done`  out  1: one-cycle pulse when the line is complete.
- `overrun`  out  1: one-cycle pulse when `line_start` arrives while `busy`.

## Operation
- Attribute table:
  - 32 × 26-bit register file, all entries cleared to 0 on reset.
  - Writes are accepted in any state and take effect the next cycle.
  - The entry being drawn is latched when its SCAN hit is taken, so a mid-draw write to that slot does not affect the current draw.
- FSM states: IDLE, SCAN, DRAW, DRAIN, DONE.
  - IDLE: wait for `line_start`. Latch `next_line`, set `lb_sel` = `next_line[0]`, clear `idx` to 0, go to SCAN.
  - SCAN: evaluate entry `idx`.
    - Hit: `id != 0` and `y <= next_line < y + SPR_W`. The compare uses 11-bit unsigned arithmetic with no vertical wrap.
    - On hit: latch `id`, `x`, and `row = next_line - y`, then go to DRAW.
    - On miss: if `idx` = 31 go to DONE, else increment `idx` and stay in SCAN.
  - DRAW: 32 cycles. Present `n_sprite` = `id`, `spr_line` = `row`, `spr_pixel` = p for p = 0..31, then go to DRAIN.
  - DRAIN: 1 cycle so the last ROM result is written. Then, if `idx` = 31 go to DONE, else increment `idx` and return to SCAN.
  - DONE: pulse `done` for 1 cycle, drop `busy`, go to IDLE.
- Write pipeline: one stage, aligned to the ROM latency.
  - The stage registers `valid = DRAW && (x + p < H_ACTIVE)`, with `x + p` computed at 11 bits, and `addr = x + p`.
  - The following cycle drives `lb_we` = `valid && color_code != 0`, `lb_addr` = registered addr, `lb_data` = `color_code`.
- Transparency: code 0 is never written. The display side clears each buffer after reading it; this block does not clear.
- Priority: slots are drawn in ascending index order, so a higher index overwrites a lower one where sprites overlap.
- `line_start` while `busy`:
  - Pulse `overrun`, discard the pending pipeline write (`lb_we` forced to 0 that cycle).
  - Restart from `idx` 0 with the new `next_line` and `lb_sel`, entering SCAN next cycle.
  - No `done` is issued for the aborted line.
- `line_start` coincident with `done`: treated as a new start from IDLE; no overrun.
- `reset` mid-render: everything returns to reset state next cycle and the table is cleared.

## Timing
- Reset values: `n_sprite`, `spr_line`, `spr_pixel`, `lb_addr`, `lb_data` = 0; `lb_we`, `lb_sel`, `busy`, `done`, `overrun` = 0.
- With `line_start` at cycle T:
  - First SCAN is at T+1.
  - A miss costs 1 cycle; a hit costs 34 cycles (SCAN + 32 DRAW + DRAIN).
  - `done` = T + 33 + 33·hits. Worst case (32 hits) = T + 1089, inside a 1600-cycle line at 50 MHz.
- For a hit scanned at cycle S: `spr_pixel` = p at S+1+p; the matching `lb_we` is at S+2+p.
- All outputs are registered except `lb_we` and `lb_data`, which depend on `color_code`.

## Test plan
- Empty table, `line_start` with `next_line` = 10 at T → `busy` T+1..T+33, `done` at T+33, `lb_we` never asserted.
- Slot 0 = {id 20, y 50, x 100}, `next_line` = 53 at T → `n_sprite` = 20, `spr_line` = 3, `spr_pixel` 0..31 at T+2..T+33. Nonzero codes are written to `lb_addr` 100..131 at T+3..T+34. `lb_sel` = 1, `done` at T+66.
- Slot 0 x = 620 → writes only at addresses 620..639; `spr_pixel` still runs 0..31; `done` timing unchanged.
- Vertical bounds with y = 50: `next_line` 49 and 82 → no draw; 50 → `spr_line` 0; 81 → `spr_line` 31. With y = 1000, `next_line` 5 → no draw.
- Slots 2 and 5 at the same x and y → slot 5 writes occur after slot 2 writes at the same addresses; `done` at T+99.
- Second `line_start` (`next_line` 54) at T+20 during a draw → `overrun` pulse, no `lb_we` at T+20, SCAN of slot 0 at T+21 with `spr_line` 4, `lb_sel` 0, single `done` at T+86.
